// File: rtl/nano_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory.
// The arbiter takes the slave view; the requesters and the memory array
// together take the master view.
interface nano_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  // Requester 0 (NanoCPU)
  logic          req0;
  logic          lock0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          ack0;
  logic [DW-1:0] rdata0;
  // Requester 1 (loader/debug)
  logic          req1;
  logic          lock1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          ack1;
  logic [DW-1:0] rdata1;
  // Memory side
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_dataW;
  logic [DW-1:0] mem_dataR;
  // Status
  logic          lock_err;

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    input  req1, lock1, we1, addr1, wdata1,
    input  mem_dataR,
    output gnt0, ack0, rdata0,
    output gnt1, ack1, rdata1,
    output mem_ce, mem_we, mem_address, mem_dataW,
    output lock_err
  );

  modport master (
    output req0, lock0, we0, addr0, wdata0,
    output req1, lock1, we1, addr1, wdata1,
    output mem_dataR,
    input  gnt0, ack0, rdata0,
    input  gnt1, ack1, rdata1,
    input  mem_ce, mem_we, mem_address, mem_dataW,
    input  lock_err
  );
endinterface

// File: rtl/nano_mem_arbiter.sv
// Two-port arbiter for the single 256x16 NanoCPU memory.
// Port 0 (CPU) has fixed priority; port 1 is protected by a starvation
// guard (wait1) and either port may lock the memory for read-modify-write,
// bounded by LOCK_MAX cycles. Grants and the memory mux are combinational;
// ack, rdata and lock_err are registered.
module nano_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic                  ck,
  input  logic                  rst,
  nano_mem_arbiter_if.slave     bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [WW-1:0] WAIT_SAT  = WW'(MAX_WAIT);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q;
  logic [WW-1:0] wait1_q;
  logic [CW-1:0] lock_cnt_q;
  // Set on a forced release; a port must drop lock (or req) before relocking.
  logic          relock_blk0_q;
  logic          relock_blk1_q;
  logic          ack0_q;
  logic          ack1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          lock_err_q;

  logic          gnt0_s;
  logic          gnt1_s;
  logic          mem_ce_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s;

  // Grant decision: priority in IDLE, exclusive ownership in OWN0/OWN1.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req0 && !bus.req1) begin
            gnt0_s = 1'b1;
          end else if (bus.req1 && !bus.req0) begin
            gnt1_s = 1'b1;
          end else if (bus.req0 && bus.req1) begin
            if (wait1_q >= WAIT_SAT) begin
              gnt1_s = 1'b1;
            end else begin
              gnt0_s = 1'b1;
            end
          end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
          end
        end
        OWN0: begin
          gnt0_s = bus.req0;
        end
        OWN1: begin
          gnt1_s = bus.req1;
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Memory mux: the granted port drives the array; idle bus is all zeros.
  always_comb begin
    mem_ce_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    if (gnt0_s) begin
      mem_ce_s    = 1'b1;
      mem_we_s    = bus.we0;
      mem_addr_s  = bus.addr0;
      mem_wdata_s = bus.wdata0;
    end else if (gnt1_s) begin
      mem_ce_s    = 1'b1;
      mem_we_s    = bus.we1;
      mem_addr_s  = bus.addr1;
      mem_wdata_s = bus.wdata1;
    end else begin
      mem_ce_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = '0;
      mem_wdata_s = '0;
    end
  end

  // Ownership FSM together with starvation counter and registered completions.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q       <= IDLE;
      wait1_q       <= '0;
      lock_cnt_q    <= '0;
      relock_blk0_q <= 1'b0;
      relock_blk1_q <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      lock_err_q    <= 1'b0;
    end else begin
      // Completion: read data captured at the same edge the write lands,
      // so a write returns the pre-write contents.
      ack0_q <= gnt0_s;
      ack1_q <= gnt1_s;
      if (gnt0_s) begin
        rdata0_q <= bus.mem_dataR;
      end
      if (gnt1_s) begin
        rdata1_q <= bus.mem_dataR;
      end

      // Starvation counter counts denied port-1 cycles in every state.
      if (!bus.req1 || gnt1_s) begin
        wait1_q <= '0;
      end else if (wait1_q != WAIT_SAT) begin
        wait1_q <= wait1_q + 1'b1;
      end else begin
        wait1_q <= wait1_q;
      end

      lock_err_q <= 1'b0;

      if (!bus.lock0 || !bus.req0) begin
        relock_blk0_q <= 1'b0;
      end
      if (!bus.lock1 || !bus.req1) begin
        relock_blk1_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          lock_cnt_q <= '0;
          if (gnt0_s && bus.lock0 && !relock_blk0_q) begin
            state_q <= OWN0;
          end else if (gnt1_s && bus.lock1 && !relock_blk1_q) begin
            state_q <= OWN1;
          end else begin
            state_q <= IDLE;
          end
        end
        OWN0: begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b1;
            if (bus.lock0 && bus.req0) begin
              relock_blk0_q <= 1'b1;
            end
          end else if (!bus.lock0) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        OWN1: begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            lock_err_q <= 1'b1;
            if (bus.lock1 && bus.req1) begin
              relock_blk1_q <= 1'b1;
            end
          end else if (!bus.lock1) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          lock_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.gnt0        = gnt0_s;
  assign bus.gnt1        = gnt1_s;
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.mem_ce      = mem_ce_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_address = mem_addr_s;
  assign bus.mem_dataW   = mem_wdata_s;
  assign bus.lock_err    = lock_err_q;

endmodule
